sgpio_led_arbiter: RTL

Shares the single SGPIO LED shifter between several status sources. Each requester offers one 8-bit LED pattern with a valid/ready handshake. The block picks requesters round-robin and emits the pattern as the one-cycle `i_data`/`i_valid` pulse the shifter consumes. It then holds off further issues until the shifter has had a full serial frame to shift the byte out. When no requester is active, it periodically re-sends the last pattern so the LED state is refreshed.

---
 rtl/sgpio_led_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sgpio_led_arbiter.sv
// rtl/sgpio_led_arbiter.sv - round-robin arbiter feeding one SGPIO LED shifter
// Spaces shifter issues a full frame apart and re-sends the last byte when idle.
module sgpio_led_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FRAME_CYCLES   = 5000,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       en,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [7:0]                 o_data,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int RW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [7:0]    last_q, last_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [RW-1:0] refresh_q, refresh_d;

  logic          found;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;
  logic [7:0]    win_byte;
  logic [NUM_REQ-1:0] ready_c;

  // First valid requester strictly after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (GW'(k) == win) win_byte = i_req_data[k*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    last_d    = last_q;
    frame_d   = frame_q;
    refresh_d = refresh_q;
    ready_c   = '0;
    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          ready_c[win] = 1'b1;
          last_d       = win_byte;
          ptr_d        = win;
          grant_d      = win;
          refresh_d    = '0;
          state_d      = S_ISSUE;
        end else if (en && REFRESH_CYCLES != 0) begin
          // Threshold at REFRESH_CYCLES puts the refresh pulse REFRESH_CYCLES+1 after idle entry.
          if (refresh_q == RW'(REFRESH_CYCLES)) begin
            refresh_d = '0;
            state_d   = S_ISSUE;
          end else begin
            refresh_d = refresh_q + 1'b1;
          end
        end else begin
          refresh_d = '0;
        end
      end
      S_ISSUE: begin
        frame_d = FW'(FRAME_CYCLES - 2);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (frame_q == '0) begin
          state_d   = S_IDLE;
          refresh_d = '0;
        end else begin
          frame_d = frame_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      ptr_q     <= GW'(NUM_REQ - 1);
      grant_q   <= '0;
      last_q    <= '0;
      frame_q   <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      frame_q   <= frame_d;
      refresh_q <= refresh_d;
    end
  end

  // Ready is combinational, so it must also be forced low while reset is held.
  assign o_req_ready = ready_c & {NUM_REQ{aresetn}};
  assign o_valid     = (state_q == S_ISSUE);
  assign o_data      = o_valid ? last_q : 8'h00;
  assign o_busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign o_grant_id  = grant_q;

endmodule
